// File: rtl/pll_lock_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_gen
// Description : PLL lock supervisor and system reset generator. Synchronizes
//               the asynchronous PLL lock, debounces it, and releases the
//               downstream synchronous reset only after lock has been stable
//               for LOCK_WAIT cycles. Drops that reset at once on lock loss,
//               re-resets the PLL when lock never arrives, and keeps
//               lock-loss / timeout status for debug.
// Ports       : clk           - free-running PLL reference clock (not a PLL output)
//               rst_n         - asynchronous active-low reset
//               pll_lock      - PLL lock, asynchronous to clk
//               pll_rst_req   - single-cycle soft request to re-reset the PLL
//               pll_rst       - registered active-high reset to the PLL
//               sys_rst_n     - registered active-low reset for downstream logic
//               locked        - high exactly while in RUN
//               lock_loss_cnt - saturating count of lock losses seen in RUN
//               timeout_err   - sticky: MAX_RETRY timeouts since last RUN entry
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_rst_gen #(
    parameter int LOCK_WAIT    = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PLL_RST_CYC  = 16,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             pll_rst_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             locked,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             timeout_err
);

    // One timer is shared by all timed states, so it is sized for the longest.
    localparam int c_TMAX_A   = (LOCK_TIMEOUT > LOCK_WAIT) ? LOCK_TIMEOUT : LOCK_WAIT;
    localparam int c_TMAX     = (c_TMAX_A > PLL_RST_CYC) ? c_TMAX_A : PLL_RST_CYC;
    localparam int c_TIMER_W  = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam int c_RETRY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST  = c_TIMER_W'(PLL_RST_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_WAIT_LAST = c_TIMER_W'(LOCK_WAIT - 1);
    localparam logic [c_TIMER_W-1:0] c_TO_LAST   = c_TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_DEBOUNCE  = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_sat;
    logic                   w_timeout;
    logic                   w_loss;
    logic                   w_timer_clr;

    // Two-flop synchronizer; only r_lock_s is used past this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET_PLL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. The soft request overrides every other transition,
    // which also suppresses a lock-loss count or timeout in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_loss    = 1'b0;
        if (pll_rst_req) begin
            w_next = S_RESET_PLL;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == c_RST_LAST) w_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_next = S_DEBOUNCE;
                    end else if (r_timer == c_TO_LAST) begin
                        w_next    = S_RESET_PLL;
                        w_timeout = 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!r_lock_s) begin
                        w_next = S_WAIT_LOCK;
                    end else if (r_timer == c_WAIT_LAST) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_next = S_WAIT_LOCK;
                        w_loss = 1'b1;
                    end
                end
                default: w_next = S_RESET_PLL;
            endcase
        end
    end

    // Timer restarts on every state change (and on a soft request, which may
    // re-enter RESET_PLL from RESET_PLL). It idles at zero in RUN.
    assign w_timer_clr = pll_rst_req || (w_next != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (r_state != S_RUN) begin
            r_timer <= r_timer + c_TIMER_W'(1);
        end
    end

    assign w_retry_sat = (r_retry == c_MAX_RETRY) ? r_retry : r_retry + c_RETRY_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (w_next == S_RUN && r_state != S_RUN) begin
                r_retry <= '0;
            end else if (w_timeout) begin
                r_retry <= w_retry_sat;
            end
            if (w_timeout && (w_retry_sat == c_MAX_RETRY)) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (w_loss && (lock_loss_cnt != {CNT_W{1'b1}})) begin
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
        end else begin
            pll_rst   <= (w_next == S_RESET_PLL);
            sys_rst_n <= (w_next == S_RUN);
            locked    <= (w_next == S_RUN);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_rst_gen
// Description : Directed self-checking bench for pll_lock_rst_gen with
//               LOCK_WAIT=8, LOCK_TIMEOUT=64, PLL_RST_CYC=4, MAX_RETRY=2,
//               CNT_W=4 and a 50 MHz clock.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_lock_rst_gen;

    logic       clk_tb = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_rst_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked;
    logic [3:0] lock_loss_cnt;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    always #10 clk_tb = ~clk_tb;

    pll_lock_rst_gen #(
        .LOCK_WAIT    (8),
        .LOCK_TIMEOUT (64),
        .PLL_RST_CYC  (4),
        .MAX_RETRY    (2),
        .CNT_W        (4)
    ) dut (
        .clk           (clk_tb),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .pll_rst_req   (pll_rst_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .locked        (locked),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_err   (timeout_err)
    );

    // Advance n rising edges; land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_tb);
            #1;
        end
    endtask

    // Hold reset for two edges and release just after an edge; the next edge
    // is edge 1 after release.
    task automatic do_reset();
        rst_n       = 1'b0;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b0;
        tick(3);
        checks++;
        if ({pll_rst, sys_rst_n, locked, lock_loss_cnt, timeout_err} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got pll_rst=%b sys_rst_n=%b locked=%b cnt=%0d terr=%b, want 1 0 0 0 0",
                     pll_rst, sys_rst_n, locked, lock_loss_cnt, timeout_err);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            checks++;
            if (pll_rst !== (e < 4) || sys_rst_n !== 1'b0) begin
                failures++;
                $display("FAIL release_pll_rst edge %0d: got pll_rst=%b sys_rst_n=%b, want %b 0",
                         e, pll_rst, sys_rst_n, (e < 4));
            end
        end
    endtask

    // Continues from test_reset: now in WAIT_LOCK.
    task automatic test_normal_lock();
        pll_lock = 1'b1;   // first sampled at the next edge N
        for (int k = 1; k <= 11; k++) begin
            tick(1);       // now after edge N+k-1
            checks++;
            if (sys_rst_n !== (k == 11) || locked !== (k == 11)) begin
                failures++;
                $display("FAIL normal_lock edge N+%0d: got sys_rst_n=%b locked=%b, want %b",
                         k - 1, sys_rst_n, locked, (k == 11));
            end
        end
        checks++;
        if (lock_loss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL normal_lock_cnt: got %0d want 0", lock_loss_cnt);
        end
    endtask

    task automatic test_glitchy_lock();
        logic saw_rel;
        saw_rel = 1'b0;
        do_reset();
        tick(4);
        for (int r = 0; r < 3; r++) begin
            pll_lock = 1'b1;
            for (int i = 0; i < 5; i++) begin tick(1); saw_rel |= sys_rst_n; end
            pll_lock = 1'b0;
            for (int i = 0; i < 5; i++) begin tick(1); saw_rel |= sys_rst_n; end
        end
        checks++;
        if (saw_rel !== 1'b0) begin
            failures++;
            $display("FAIL glitch_no_release: sys_rst_n rose, want never");
        end
        checks++;
        if (lock_loss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL glitch_cnt: got %0d want 0", lock_loss_cnt);
        end
        pll_lock = 1'b1;
        tick(10);
        checks++;
        if (sys_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL glitch_early: sys_rst_n=%b at N+9, want 0", sys_rst_n);
        end
        tick(1);
        checks++;
        if (sys_rst_n !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL glitch_final_release: got sys_rst_n=%b locked=%b want 1 1", sys_rst_n, locked);
        end
    endtask

    task automatic test_lock_loss();
        logic saw_pll_rst;
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        pll_lock = 1'b0;   // first sampled low at next edge N
        tick(2);           // after N+1
        checks++;
        if (sys_rst_n !== 1'b1 || lock_loss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL loss_early: at N+1 got sys_rst_n=%b cnt=%0d want 1 0", sys_rst_n, lock_loss_cnt);
        end
        tick(1);           // after N+2
        checks++;
        if (sys_rst_n !== 1'b0 || locked !== 1'b0 || lock_loss_cnt !== 4'd1) begin
            failures++;
            $display("FAIL loss_at_n2: got sys_rst_n=%b locked=%b cnt=%0d want 0 0 1",
                     sys_rst_n, locked, lock_loss_cnt);
        end
        saw_pll_rst = 1'b0;
        pll_lock = 1'b1;
        for (int i = 0; i < 11; i++) begin tick(1); saw_pll_rst |= pll_rst; end
        for (int r = 0; r < 19; r++) begin
            pll_lock = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); saw_pll_rst |= pll_rst; end
            pll_lock = 1'b1;
            for (int i = 0; i < 11; i++) begin tick(1); saw_pll_rst |= pll_rst; end
        end
        checks++;
        if (lock_loss_cnt !== 4'd15 || locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_saturate: got cnt=%0d locked=%b want 15 1", lock_loss_cnt, locked);
        end
        checks++;
        if (saw_pll_rst !== 1'b0) begin
            failures++;
            $display("FAIL loss_no_pll_rst: pll_rst pulsed, want never");
        end
    endtask

    task automatic test_no_lock();
        int  bad;
        logic exp;
        bad = 0;
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            tick(1);
            exp = (e < 4) || (e >= 68 && e < 72) || (e >= 136 && e < 140);
            if (pll_rst !== exp) bad++;
            if (e == 135) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early: got %b at edge 135 want 0", timeout_err);
                end
            end
            if (e == 136) begin
                checks++;
                if (timeout_err !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_set: got %b at edge 136 want 1", timeout_err);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_lock_pll_rst_pattern: %0d edges differ, want 0", bad);
        end
        pll_lock = 1'b1;
        tick(11);
        checks++;
        if (locked !== 1'b1 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got locked=%b terr=%b want 1 1", locked, timeout_err);
        end
    endtask

    task automatic test_priority();
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL prio_setup: locked=%b want 1", locked);
        end
        pll_lock = 1'b0;   // sampled at N; lock_s low after N+1
        tick(2);
        pll_rst_req = 1'b1;
        tick(1);           // edge N+2: request and lock fall together
        pll_rst_req = 1'b0;
        checks++;
        if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 || lock_loss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL prio_req: got pll_rst=%b sys_rst_n=%b locked=%b cnt=%0d want 1 0 0 0",
                     pll_rst, sys_rst_n, locked, lock_loss_cnt);
        end
        tick(3);
        checks++;
        if (pll_rst !== 1'b1) begin
            failures++;
            $display("FAIL prio_pulse_hold: pll_rst=%b 3 edges later want 1", pll_rst);
        end
        tick(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            failures++;
            $display("FAIL prio_pulse_end: pll_rst=%b 4 edges later want 0", pll_rst);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        pll_lock = 1'b0;
        tick(3);           // lock lost, count now 1
        pll_lock = 1'b1;
        tick(5);           // in DEBOUNCE
        checks++;
        if (lock_loss_cnt !== 4'd1 || pll_rst !== 1'b0 || sys_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL async_setup: got cnt=%0d pll_rst=%b sys_rst_n=%b want 1 0 0",
                     lock_loss_cnt, pll_rst, sys_rst_n);
        end
        #4;
        rst_n = 1'b0;      // mid-cycle, well before the next edge
        #2;
        checks++;
        if ({pll_rst, sys_rst_n, locked, lock_loss_cnt, timeout_err} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: got pll_rst=%b sys_rst_n=%b locked=%b cnt=%0d terr=%b want 1 0 0 0 0",
                     pll_rst, sys_rst_n, locked, lock_loss_cnt, timeout_err);
        end
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_normal_lock();
        test_glitchy_lock();
        test_lock_loss();
        test_no_lock();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_rst_gen.md
# pll_lock_rst_gen

PLL lock supervisor and system reset generator. It sits directly downstream of the `pll` instance and consumes `pll_lock`. It also drives `pll_rst` back to the PLL. It debounces lock, releases the design's synchronous reset only after lock has been stable for a set time, and reasserts that reset immediately on lock loss. It retries the PLL with a reset pulse when lock never arrives, and keeps lock-loss and timeout status for debug.

## Interface
Parameters:
- `LOCK_WAIT`, 1024: consecutive synchronized-lock cycles required before reset release (≥2).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before the PLL is re-reset (≥2).
- `PLL_RST_CYC`, 16: width of each `pll_rst` pulse in cycles (≥1).
- `MAX_RETRY`, 3: timeouts since the last RUN entry that set `timeout_err` (≥1).
- `CNT_W`, 8: width of `lock_loss_cnt`.

Ports:
- `clk`, in, 1: free-running PLL input reference clock (`clkin1`, 50 MHz); never a PLL output.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_lock`, in, 1: PLL lock, asynchronous to `clk`.
- `pll_rst_req`, in, 1: single-cycle soft request to re-reset the PLL, synchronous to `clk`.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `sys_rst_n`, out, 1: registered active-low reset for downstream logic, synchronous to `clk`.
- `locked`, out, 1: high exactly while in RUN.
- `lock_loss_cnt`, out, CNT_W: saturating count of lock losses seen in RUN.
- `timeout_err`, out, 1: sticky flag, cleared only by `rst_n`.

## Operation
- **Synchronizer:** `pll_lock` passes through a 2-FF synchronizer to give `lock_s`. Only `lock_s` is used internally.
- **Timer:** one shared counter, width ceil(log2(max(LOCK_TIMEOUT, LOCK_WAIT, PLL_RST_CYC))). It is cleared on every state change.
- **retry_cnt:** internal, saturates at `MAX_RETRY`, cleared on entry to RUN.
- **States:**
  - RESET_PLL: `pll_rst`=1. When timer reaches `PLL_RST_CYC`-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `lock_s`=1, go to DEBOUNCE. Otherwise, when timer reaches `LOCK_TIMEOUT`-1: increment `retry_cnt`, set `timeout_err` if the incremented value equals `MAX_RETRY`, and go to RESET_PLL. Retries continue indefinitely.
  - DEBOUNCE: if `lock_s`=0, go to WAIT_LOCK with no count change. If timer reaches `LOCK_WAIT`-1 with `lock_s`=1, go to RUN.
  - RUN: if `lock_s`=0, increment `lock_loss_cnt` (saturating at 2^CNT_W-1) and go to WAIT_LOCK. The PLL is not re-reset; the PLL is allowed to relock on its own.
- **Soft request:** `pll_rst_req`=1 forces RESET_PLL from any state with the timer cleared. It has priority over every other transition in the same cycle, and `lock_loss_cnt` is not incremented even if `lock_s` falls in that cycle.
- **Outputs:** `sys_rst_n` and `locked` are registered and equal 1 only when the next state is RUN. `pll_rst` is registered and equals 1 only when the next state is RESET_PLL.

## Timing
- **Reset values** (while `rst_n`=0, asynchronously): state RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `locked`=0, `lock_loss_cnt`=0, `timeout_err`=0, synchronizer, timer and `retry_cnt` all 0.
- **After `rst_n` release:** `pll_rst` stays high for `PLL_RST_CYC` rising edges, then falls.
- **Lock rise:** `pll_lock` first sampled high at edge N, and held, gives `sys_rst_n`/`locked` = 1 after edge N+`LOCK_WAIT`+2.
- **Lock fall in RUN:** `pll_lock` first sampled low at edge N gives `sys_rst_n`=0, `locked`=0 and `lock_loss_cnt`+1, all after edge N+2.
- **Soft request:** `pll_rst_req` at edge N gives `pll_rst`=1 and `sys_rst_n`=0 after edge N.
- **Mid-operation reset:** `rst_n` asserted in any state returns all outputs to reset values with no wait for a clock. `timeout_err` clears only here.
- **Counter saturation:** `lock_loss_cnt` holds at maximum and `retry_cnt` holds at `MAX_RETRY`. Neither wraps.

## Test plan
Parameters for all scenarios: `LOCK_WAIT`=8, `LOCK_TIMEOUT`=64, `PLL_RST_CYC`=4, `MAX_RETRY`=2, `CNT_W`=4. `clk` is 50 MHz.

1. **Reset release:** release `rst_n`, hold `pll_lock`=0 -> `pll_rst`=1 for exactly 4 cycles, then 0; `sys_rst_n`=0 throughout.
2. **Normal lock:** raise `pll_lock` at sample edge N and hold it -> `sys_rst_n`=`locked`=1 after edge N+10; `lock_loss_cnt`=0.
3. **Glitchy lock:** `pll_lock` high for 5 cycles then low, repeated 3 times -> `sys_rst_n` never rises and `lock_loss_cnt` stays 0. Then hold `pll_lock` high -> release 10 cycles after its final rise.
4. **Lock loss in RUN:** drop `pll_lock` at edge N -> `sys_rst_n`=0 after edge N+2 and `lock_loss_cnt`=1. Run 20 loss/relock cycles -> `lock_loss_cnt`=15 (saturated) and `pll_rst` never pulses.
5. **No lock:** keep `pll_lock`=0 -> `pll_rst` re-pulses for 4 cycles every 68 cycles. `timeout_err`=1 after the second timeout and stays 1 after a later successful lock.
6. **Priority and async reset:** `pll_rst_req` in the same cycle as a `pll_lock` fall in RUN -> RESET_PLL, `pll_rst`=1, `lock_loss_cnt` unchanged. `rst_n` asserted mid-DEBOUNCE -> all outputs reach reset values before the next `clk` edge.
